// File: rtl/orb_pp_pkg.sv
// Shared definitions for the orbit ping-pong frame buffer controller:
// default widths, bank encodings and the fill-side state encoding.
// No ports; imported by orb_pingpong_ctrl and sat_counter users.
package orb_pp_pkg;

    localparam int AW_DEF = 11;   // 2048 words per bank
    localparam int DW_DEF = 12;   // orbit word width
    localparam int CW_DEF = 8;    // telemetry counter width

    localparam logic BANK_A = 1'b0;
    localparam logic BANK_B = 1'b1;

    typedef enum logic {
        FILL = 1'b0,              // fill bank accepting writes
        FULL = 1'b1               // fill bank holds a complete frame
    } pp_state_t;

endpackage

// File: rtl/orb_pingpong_ctrl_sat_counter.sv
// Saturating up-counter used for underrun/overrun telemetry.
// Latency: count updates on the clock edge after i_inc; holds at 2^W-1.
// Backpressure: none; increments beyond saturation are silently dropped.
// Ports: i_clk clock, i_rst_n synchronous active-low clear, i_inc increment
// strobe, o_cnt current count.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/orb_pingpong_ctrl.sv
// Ping-pong bank sequencer between the LCB packer (writer) and orbit serializer (reader).
// Latency: write 1 cycle to bank ports; read 2 cycles rd_en -> rd_data/rd_valid.
// Backpressure: none; writes while the fill bank is full are dropped and counted.
// Ports: writer (wr_*), reader (rd_*), bank A/B RAM ports (a_*/b_*, ram_wdata),
// status (fill_bank, frame_ready) and telemetry counters (underrun_cnt, overrun_cnt).
module orb_pingpong_ctrl
    import orb_pp_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_last,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    input  logic          rd_swap,
    output logic [DW-1:0] ram_wdata,
    output logic          a_wren,
    output logic          b_wren,
    output logic [AW-1:0] a_wraddr,
    output logic [AW-1:0] b_wraddr,
    output logic          a_rden,
    output logic          b_rden,
    output logic [AW-1:0] a_rdaddr,
    output logic [AW-1:0] b_rdaddr,
    input  logic [DW-1:0] a_q,
    input  logic [DW-1:0] b_q,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          fill_bank,
    output logic          frame_ready,
    output logic [CW-1:0] underrun_cnt,
    output logic [CW-1:0] overrun_cnt
);

    pp_state_t     r_state;
    logic          r_fill_bank;
    logic          r_frame_ready;
    logic          r_a_wren, r_b_wren;
    logic [AW-1:0] r_wraddr;
    logic [DW-1:0] r_wdata;
    logic          r_a_rden, r_b_rden;
    logic [AW-1:0] r_rdaddr;
    // Bank tag and valid travel alongside each read so a swap cannot
    // redirect a request that is already in flight.
    logic          r_tag1, r_vld1;
    logic          r_tag2, r_rd_valid;

    logic w_play_bank;
    logic w_wr_acc;
    logic w_wr_done;
    logic w_underrun;
    logic w_overrun;

    assign w_play_bank = ~r_fill_bank;
    assign w_wr_acc    = wr_en && (r_state == FILL);
    assign w_wr_done   = w_wr_acc && wr_last;
    // A frame completing in the swap cycle counts as ready: no underrun.
    assign w_underrun  = rd_swap && (r_state == FILL) && !w_wr_done;
    assign w_overrun   = wr_en && (r_state == FULL);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= FILL;
            r_fill_bank   <= BANK_A;
            r_frame_ready <= 1'b0;
            r_a_wren      <= 1'b0;
            r_b_wren      <= 1'b0;
            r_wraddr      <= '0;
            r_wdata       <= '0;
            r_a_rden      <= 1'b0;
            r_b_rden      <= 1'b0;
            r_rdaddr      <= '0;
            r_tag1        <= 1'b0;
            r_vld1        <= 1'b0;
            r_tag2        <= 1'b0;
            r_rd_valid    <= 1'b0;
        end else begin
            // Write path: steer to the current fill bank only.
            r_a_wren <= w_wr_acc && (r_fill_bank == BANK_A);
            r_b_wren <= w_wr_acc && (r_fill_bank == BANK_B);
            if (w_wr_acc) begin
                r_wraddr <= wr_addr;
                r_wdata  <= wr_data;
            end

            // Read path: steer to the play bank as it stands this cycle.
            r_a_rden <= rd_en && (w_play_bank == BANK_A);
            r_b_rden <= rd_en && (w_play_bank == BANK_B);
            if (rd_en) begin
                r_rdaddr <= rd_addr;
            end
            r_tag1     <= w_play_bank;
            r_vld1     <= rd_en;
            r_tag2     <= r_tag1;
            r_rd_valid <= r_vld1;

            // Fill-side sequencing.
            case (r_state)
                FILL: begin
                    if (w_wr_done && rd_swap) begin
                        r_fill_bank   <= ~r_fill_bank;
                        r_frame_ready <= 1'b0;
                    end else if (w_wr_done) begin
                        r_state       <= FULL;
                        r_frame_ready <= 1'b1;
                    end
                end
                FULL: begin
                    if (rd_swap) begin
                        r_state       <= FILL;
                        r_fill_bank   <= ~r_fill_bank;
                        r_frame_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= FILL;
                    r_frame_ready <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(.W(CW)) u_underrun (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_inc   (w_underrun),
        .o_cnt   (underrun_cnt)
    );

    sat_counter #(.W(CW)) u_overrun (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_inc   (w_overrun),
        .o_cnt   (overrun_cnt)
    );

    assign ram_wdata   = r_wdata;
    assign a_wren      = r_a_wren;
    assign b_wren      = r_b_wren;
    assign a_wraddr    = r_wraddr;
    assign b_wraddr    = r_wraddr;
    assign a_rden      = r_a_rden;
    assign b_rden      = r_b_rden;
    assign a_rdaddr    = r_rdaddr;
    assign b_rdaddr    = r_rdaddr;
    // Bank RAMs are registered, so the returning word lines up with the tag.
    assign rd_data     = r_rd_valid ? (r_tag2 ? b_q : a_q) : '0;
    assign rd_valid    = r_rd_valid;
    assign fill_bank   = r_fill_bank;
    assign frame_ready = r_frame_ready;

endmodule

// File: doc/orb_pingpong_ctrl.md
Name: orb_pingpong_ctrl

Overview:
- Sequencing controller for the two-bank ping-pong frame buffer between the LCB packet packer (writer) and the orbit frame serializer (reader).
- Steers writes into the fill bank and reads from the play bank, both through 1-port-write/1-port-read dual RAMs.
- Swaps banks only at the reader's frame boundary, and only when the fill bank holds a complete frame.
- Counts underruns (frame not ready at swap) and overruns (writes arriving while the fill bank is full) for telemetry.

Parameters:
- AW, 11, RAM address width (2048 words per bank)
- DW, 12, orbit word width
- CW, 8, width of the saturating underrun/overrun counters

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous and active-low
- wr_en  in  1  writer word strobe
- wr_addr  in  AW  writer word address
- wr_data  in  DW  writer word
- wr_last  in  1  qualified by wr_en; this word completes the frame
- rd_en  in  1  reader word request
- rd_addr  in  AW  reader word address
- rd_swap  in  1  one-cycle pulse at the reader frame boundary
- ram_wdata  out  DW  write data, shared by both banks
- a_wren / b_wren  out  1  bank write enables
- a_wraddr / b_wraddr  out  AW  bank write addresses
- a_rden / b_rden  out  1  bank read enables
- a_rdaddr / b_rdaddr  out  AW  bank read addresses
- a_q / b_q  in  DW  bank read data; registered, one-cycle latency
- rd_data  out  DW  word returned to the reader
- rd_valid  out  1  rd_data valid
- fill_bank  out  1  bank being written (0 = A, 1 = B)
- frame_ready  out  1  fill bank holds a complete frame
- underrun_cnt  out  CW  saturating underrun count
- overrun_cnt  out  CW  saturating overrun count

Behaviour:
- Reset (rst = 0 at a clk edge) clears all RAM-facing outputs, rd_data, rd_valid, frame_ready, both counters, and the read pipeline tags.
- Reset sets fill_bank = 0, play bank = 1, state = FILL. Reset mid-frame discards the partial frame; RAM contents are untouched.
- Play bank is always ~fill_bank.
- State machine (fill side):
  - FILL: accept writes.
  - FULL: frame_ready = 1; reject writes.
- FILL -> FULL on wr_en & wr_last.
- FULL -> FILL on rd_swap; fill_bank toggles.
- rd_swap in FILL:
  - no toggle; underrun_cnt += 1 (saturates at 2^CW-1).
  - reader replays the old play bank.
- rd_swap in the same cycle as wr_en & wr_last while in FILL:
  - the last word is written to the current fill bank;
  - the swap happens (counts as FULL); no underrun.
- Write path, registered, 1-cycle latency:
  - wr_en accepted at cycle n -> x_wren, x_wraddr, ram_wdata driven at n+1 on the fill bank only; the other bank's wren = 0.
  - In FULL, wr_en is dropped: no wren, overrun_cnt += 1 (saturating).
  - wr_last in FULL is ignored.
- Read path:
  - rd_en at cycle n -> x_rden and x_rdaddr registered at n+1 on the play bank; the other bank's rden = 0.
  - x_q valid at n+2 -> rd_data = mux(bank tag) combinational, rd_valid = 1 at n+2.
  - The bank tag travels with the request. Reads issued up to and including the rd_swap cycle use the pre-swap play bank; a swap never corrupts in-flight reads.
  - Back-to-back rd_en gives one word per cycle.
- A bank is never written and read by this controller in the same cycle. Write and read address spaces wrap naturally at 2^AW; no address check.
- Counter increments and state change in the same cycle are independent; both take effect.

Decomposition:
- Package orb_pp_pkg:
  - AW/DW/CW defaults
  - bank encoding constants BANK_A = 0, BANK_B = 1
  - state enum {FILL, FULL}
- One natural sub-module: sat_counter (CW-bit saturating increment, synchronous active-low clear). Instantiated twice for underrun and overrun.

Test Plan:
- Reset: hold rst = 0 for 3 clk with random inputs -> fill_bank = 0, frame_ready = 0, all wren/rden = 0, counters = 0, rd_valid = 0.
- Fill and swap:
  - Stimulus: write 4 words addr 0..3, data 0x100..0x103, wr_last on addr 3; then rd_swap.
  - Required: a_wren pulses with matching addr/data one cycle after each wr_en; frame_ready = 1 after the last write; after rd_swap, fill_bank = 1 and frame_ready = 0.
  - Then: rd_en addr 2 -> a_rden; rd_data = 0x102 with rd_valid two cycles later.
- Underrun: rd_swap while in FILL with 2 words written -> fill_bank unchanged, underrun_cnt = 1, subsequent writes continue into the same bank.
- Overrun: in FULL, issue 5 wr_en -> no a_wren/b_wren, overrun_cnt = 5; saturation check with CW = 2 -> count stops at 3.
- Simultaneous: wr_en & wr_last coincident with rd_swap in FILL -> last word written to the old fill bank, fill_bank toggles, underrun_cnt unchanged.
- In-flight read across swap: rd_en on the cycle of rd_swap -> data returned from the pre-swap play bank (rd_data = that bank's a_q or b_q), not the new one.
